aoi_sweep_pipe: RTL

//  Parametrised, registered AND-OR-INVERT / OR-AND-INVERT evaluator.

---
 rtl/aoi_defs.sv | 16 +
 rtl/aoi_core.sv | 24 ++
 rtl/aoi_sweep_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/aoi_defs.sv
// Shared definitions for the AOI/OAI sweep pipeline: mode encodings, FSM states, size limit.
package aoi_defs;

   localparam logic MODE_AOI = 1'b0;
   localparam logic MODE_OAI = 1'b1;

   localparam int unsigned MAX_N = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSweep = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/aoi_core.sv
// Combinational GROUPS x GROUP_W evaluator: AOI gives ~|(&grp), OAI gives ~&(|grp).
module aoi_core
   import aoi_defs::*;
#(
   parameter int unsigned GROUPS  = 3,
   parameter int unsigned GROUP_W = 3,
   localparam int unsigned N      = GROUPS * GROUP_W
) (
   input  logic [N-1:0] IN,
   input  logic         MODE,
   output logic         Y
);

   logic [GROUPS-1:0] and_g;
   logic [GROUPS-1:0] or_g;

   for (genvar g = 0; g < GROUPS; g++) begin : gen_grp
      assign and_g[g] = &IN[g*GROUP_W +: GROUP_W];
      assign or_g[g]  = |IN[g*GROUP_W +: GROUP_W];
   end

   assign Y = (MODE == MODE_AOI) ? ~|and_g : ~&or_g;

endmodule

// File: rtl/aoi_sweep_pipe.sv
// Two-stage valid-qualified AOI/OAI pipeline with an exhaustive sweep engine that counts
// how many input patterns drive Y=1.
module aoi_sweep_pipe
   import aoi_defs::*;
#(
   parameter int unsigned GROUPS  = 3,
   parameter int unsigned GROUP_W = 3,
   localparam int unsigned N      = GROUPS * GROUP_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         MODE,
   input  logic         IN_VALID,
   input  logic [N-1:0] IN,
   output logic         OUT_VALID,
   output logic         Y,
   input  logic         SWEEP_START,
   output logic         SWEEP_BUSY,
   output logic         SWEEP_DONE,
   output logic [N:0]   ONES_COUNT
);

   if (N > MAX_N) begin : gen_n_too_large
      $error("aoi_sweep_pipe: GROUPS*GROUP_W exceeds MAX_N");
   end

   localparam logic [N-1:0] CntMax = '1;

   state_e       state_q, state_d;
   logic [N-1:0] cnt_q;
   logic         sweep_mode_q;
   logic         drain_q;
   logic         s1_valid_q, s1_sweep_q, s1_mode_q;
   logic [N-1:0] s1_in_q;
   logic         out_valid_q, y_q;
   logic         s2_sweep_q, s2_y_q;
   logic [N:0]   ones_q;
   logic         core_y;
   logic         start_ok;

   assign start_ok = (state_q == StIdle) && SWEEP_START;

   aoi_core #(
      .GROUPS  (GROUPS),
      .GROUP_W (GROUP_W)
   ) u_core (
      .IN   (s1_in_q),
      .MODE (s1_mode_q),
      .Y    (core_y)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (SWEEP_START) state_d = StSweep;
         StSweep: if (cnt_q == CntMax) state_d = StDrain;
         StDrain: if (drain_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         sweep_mode_q <= 1'b0;
         drain_q      <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_sweep_q   <= 1'b0;
         s1_mode_q    <= 1'b0;
         s1_in_q      <= '0;
         out_valid_q  <= 1'b0;
         y_q          <= 1'b0;
         s2_sweep_q   <= 1'b0;
         s2_y_q       <= 1'b0;
         ones_q       <= '0;
      end else begin
         state_q <= state_d;

         // Stage 1: functional input in IDLE (a same-cycle start drops it), counter in SWEEP.
         if (state_q == StIdle) begin
            s1_valid_q <= IN_VALID & ~SWEEP_START;
            s1_sweep_q <= 1'b0;
            if (IN_VALID) begin
               s1_in_q   <= IN;
               s1_mode_q <= MODE;
            end
         end else if (state_q == StSweep) begin
            s1_valid_q <= 1'b1;
            s1_sweep_q <= 1'b1;
            s1_in_q    <= cnt_q;
            s1_mode_q  <= sweep_mode_q;
         end else begin
            s1_valid_q <= 1'b0;
            s1_sweep_q <= 1'b0;
         end

         // Stage 2: sweep results go to a private register so Y only moves with OUT_VALID.
         out_valid_q <= s1_valid_q & ~s1_sweep_q;
         s2_sweep_q  <= s1_valid_q & s1_sweep_q;
         s2_y_q      <= core_y;
         if (s1_valid_q && !s1_sweep_q) y_q <= core_y;

         if (start_ok) begin
            cnt_q        <= '0;
            ones_q       <= '0;
            sweep_mode_q <= MODE;
            drain_q      <= 1'b0;
         end else begin
            if ((state_q == StSweep) && (cnt_q != CntMax)) cnt_q <= cnt_q + 1'b1;
            if (s2_sweep_q) ones_q <= ones_q + {{N{1'b0}}, s2_y_q};
            drain_q <= (state_q == StDrain);
         end
      end
   end

   assign OUT_VALID  = out_valid_q;
   assign Y          = y_q;
   assign SWEEP_BUSY = (state_q != StIdle);
   assign SWEEP_DONE = (state_q == StDone);
   assign ONES_COUNT = ones_q;

endmodule
